// File: rtl/mac_log_pkg.sv
// Shared constants for the generation-unit log collector: header layout,
// arbiter state encoding and the header builder used by the output FSM.
package mac_log_pkg;

    localparam logic [3:0] HDR_SYNC          = 4'hA;
    localparam int         HDR_SYNC_LSB      = 28;
    localparam int         HDR_CH_LSB        = 26;
    localparam int         HDR_TRUNC_BIT     = 24;
    localparam int         HDR_SEQ_LSB       = 8;
    localparam int         HDR_CNT_LSB       = 0;
    localparam int         DEFAULT_BUF_DEPTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY
    } arb_state_e;

    typedef enum logic {
        CAP_IDLE,
        CAP_WRITE
    } cap_state_e;

    function automatic logic [31:0] make_header(input logic [1:0]  ch,
                                                input logic        trunc,
                                                input logic [15:0] seq,
                                                input logic [7:0]  cnt);
        // NOTE: blocking assignments are right here; h is a local temporary, not flop state.
        logic [31:0] h;
        h                           = '0;
        h[HDR_SYNC_LSB +: 4]        = HDR_SYNC;
        h[HDR_CH_LSB +: 2]          = ch;
        h[HDR_TRUNC_BIT]            = trunc;
        h[HDR_SEQ_LSB +: 16]        = seq;
        h[HDR_CNT_LSB +: 8]         = cnt;
        return h;
    endfunction

endpackage

// File: rtl/mac_log_collector_if.sv
// Ready/valid 32-bit log stream toward the PS log DMA.
interface mac_log_collector_if;
    logic        m_Log_Valid;
    logic [31:0] m_Log_Data;
    logic        m_Log_Last;
    logic        m_Log_Ready;

    modport master (output m_Log_Valid, m_Log_Data, m_Log_Last, input m_Log_Ready);
    modport slave  (input m_Log_Valid, m_Log_Data, m_Log_Last, output m_Log_Ready);
endinterface

// File: rtl/log_burst_buffer.sv
// One channel's burst capture: edge-detected start, saturating write pointer,
// pending/trunc status and an asynchronously read word memory.
module log_burst_buffer
    import mac_log_pkg::*;
#(
    parameter  int BUF_DEPTH = DEFAULT_BUF_DEPTH,
    localparam int AW        = $clog2(BUF_DEPTH),
    localparam int PW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Resetn,
    input  logic          cmd_i,
    input  logic [31:0]   data_i,
    input  logic          release_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    output logic          pending_o,
    output logic          trunc_o,
    output logic [7:0]    count_o,
    output logic          ovf_o,
    output logic          drop_o
);

    cap_state_e    cap_q;
    logic          cmd_q;
    logic [PW-1:0] wr_ptr_q;
    logic          pending_q;
    logic          trunc_q;
    logic [7:0]    count_q;
    logic [31:0]   mem_q [BUF_DEPTH];

    logic          start;
    logic          room;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    // A start while the previous burst still waits to drain is dropped whole.
    assign start   = cmd_i && !cmd_q;
    assign room    = wr_ptr_q < PW'(BUF_DEPTH);
    assign wr_en   = (cap_q == CAP_IDLE  && start && !pending_q) ||
                     (cap_q == CAP_WRITE && cmd_i && room);
    assign wr_addr = (cap_q == CAP_IDLE) ? '0 : wr_ptr_q[AW-1:0];
    assign ovf_o   = cap_q == CAP_WRITE && cmd_i && !room;
    assign drop_o  = cap_q == CAP_IDLE && start && pending_q;

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            cap_q     <= CAP_IDLE;
            cmd_q     <= 1'b0;
            wr_ptr_q  <= '0;
            pending_q <= 1'b0;
            trunc_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            cmd_q <= cmd_i;
            case (cap_q)
                CAP_IDLE: begin
                    if (start && !pending_q) begin
                        cap_q    <= CAP_WRITE;
                        wr_ptr_q <= PW'(1);
                        trunc_q  <= 1'b0;
                    end
                end
                CAP_WRITE: begin
                    if (!cmd_i) begin
                        cap_q     <= CAP_IDLE;
                        pending_q <= 1'b1;
                        count_q   <= 8'(wr_ptr_q);
                    end else if (room) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                    end else begin
                        trunc_q <= 1'b1;
                    end
                end
                default: cap_q <= CAP_IDLE;
            endcase
            if (release_i) begin
                pending_q <= 1'b0;
            end
        end
    end

    // NOTE: the memory has no reset; pending_q alone says whether its contents are meaningful.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
    assign pending_o = pending_q;
    assign trunc_o   = trunc_q;
    assign count_o   = count_q;

endmodule

// File: rtl/mac_log_collector.sv
// Collects per-unit log bursts and drains them as framed packets, round-robin,
// onto one ready/valid stream; keeps sticky overflow/drop flags.
module mac_log_collector
    import mac_log_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
    parameter int SEQ_W     = 16
) (
    input  logic                Clk,
    input  logic                Resetn,
    input  logic [N_CH-1:0]     s_Log_Cmd,
    input  logic [32*N_CH-1:0]  s_Log_Data,
    mac_log_collector_if.master m_log,
    input  logic                clr_flags,
    output logic [N_CH-1:0]     ovf_flags,
    output logic [N_CH-1:0]     drop_flags
);

    localparam int AW = $clog2(BUF_DEPTH);

    logic [N_CH-1:0] pending_v, trunc_v, ovf_set, drop_set, release_v;
    logic [7:0]      count_v   [N_CH];
    logic [31:0]     rd_data_v [N_CH];
    logic [AW-1:0]   rd_addr;

    arb_state_e      state_q;
    logic [1:0]      ch_q, rr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [SEQ_W-1:0] seq_q;
    logic            valid_q, last_q;
    logic [31:0]     data_q;
    logic [N_CH-1:0] ovf_q, drop_q;

    logic            accept, found;
    logic [1:0]      pick_ch, idx;

    assign accept  = valid_q && m_log.m_Log_Ready;
    // Buffers are read one word ahead so the registered output is ready on accept.
    assign rd_addr = (state_q == ST_HDR) ? '0 : rd_ptr_q + AW'(1);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign release_v[k] = state_q == ST_PAY && accept && last_q && ch_q == 2'(k);

        log_burst_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
            .Clk       (Clk),
            .Resetn    (Resetn),
            .cmd_i     (s_Log_Cmd[k]),
            .data_i    (s_Log_Data[32*k +: 32]),
            .release_i (release_v[k]),
            .rd_addr_i (rd_addr),
            .rd_data_o (rd_data_v[k]),
            .pending_o (pending_v[k]),
            .trunc_o   (trunc_v[k]),
            .count_o   (count_v[k]),
            .ovf_o     (ovf_set[k]),
            .drop_o    (drop_set[k])
        );
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        found   = 1'b0;
        pick_ch = '0;
        idx     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = 2'((int'(rr_q) + i) % N_CH);
            if (!found && pending_v[idx]) begin
                found   = 1'b1;
                pick_ch = idx;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            rr_q     <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        state_q <= ST_HDR;
                        ch_q    <= pick_ch;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        data_q  <= make_header(pick_ch, trunc_v[pick_ch], 16'(seq_q), count_v[pick_ch]);
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        state_q  <= ST_PAY;
                        seq_q    <= seq_q + SEQ_W'(1);
                        rd_ptr_q <= '0;
                        data_q   <= rd_data_v[ch_q];
                        last_q   <= count_v[ch_q] == 8'd1;
                    end
                end
                ST_PAY: begin
                    if (accept) begin
                        if (last_q) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            rr_q    <= 2'((int'(ch_q) + 1) % N_CH);
                        end else begin
                            rd_ptr_q <= rd_ptr_q + AW'(1);
                            data_q   <= rd_data_v[ch_q];
                            last_q   <= int'(rd_ptr_q) + 2 == int'(count_v[ch_q]);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A set event in the same cycle as clr_flags wins.
    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            ovf_q  <= '0;
            drop_q <= '0;
        end else begin
            ovf_q  <= (clr_flags ? '0 : ovf_q)  | ovf_set;
            drop_q <= (clr_flags ? '0 : drop_q) | drop_set;
        end
    end

    assign m_log.m_Log_Valid = valid_q;
    assign m_log.m_Log_Data  = data_q;
    assign m_log.m_Log_Last  = last_q;
    assign ovf_flags         = ovf_q;
    assign drop_flags        = drop_q;

endmodule

// File: tb/tb_mac_log_collector.sv
// Bench for mac_log_collector: directed scenarios plus random burst rounds,
// scored per channel against a frame-level reference model.
module tb_mac_log_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   cmd;
    logic [127:0] sdata;
    logic         clr;
    logic [3:0]   ovf, drop;

    mac_log_collector_if lif ();

    mac_log_collector #(.N_CH(4), .BUF_DEPTH(32), .SEQ_W(16)) dut (
        .Clk        (clk),
        .Resetn     (rst_n),
        .s_Log_Cmd  (cmd),
        .s_Log_Data (sdata),
        .m_log      (lif),
        .clr_flags  (clr),
        .ovf_flags  (ovf),
        .drop_flags (drop)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] rx_data_q [$];
    logic        rx_last_q [$];
    logic [31:0] exp_q [4][$];
    int          exp_words;
    int          model_seq;
    logic [3:0]  ovf_exp;

    int b_len   [4];
    int b_start [4];
    bit b_keep  [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge; a word transfers at the next rising edge.
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv <= 1'b0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid", 32'(lif.m_Log_Valid), 32'd1);
                check("stall_data", lif.m_Log_Data, pd);
                check("stall_last", 32'(lif.m_Log_Last), 32'(pl));
            end
            if (lif.m_Log_Valid && lif.m_Log_Ready) begin
                rx_data_q.push_back(lif.m_Log_Data);
                rx_last_q.push_back(lif.m_Log_Last);
            end
            pv <= lif.m_Log_Valid;
            pr <= lif.m_Log_Ready;
            pd <= lif.m_Log_Data;
            pl <= lif.m_Log_Last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        rx_data_q.delete();
        rx_last_q.delete();
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        exp_words = 0;
        model_seq = 0;
        ovf_exp   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd = '0;
        sdata = '0;
        clr = 1'b0;
        lif.m_Log_Ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic clear_bursts();
        for (int k = 0; k < 4; k++) begin
            b_len[k] = 0;
            b_start[k] = 0;
            b_keep[k] = 1'b1;
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Drives the configured bursts; kept bursts become expected frames.
    task automatic run_bursts(input bit pat, input int ready_pct, input bit toggle);
        logic [31:0] w [4][$];
        int last_c = 0;
        int cnt;
        bit act;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < b_len[k]; i++)
                w[k].push_back(pat ? (32'(i + 1) << 16) | 32'(k) : $urandom);
            if (b_keep[k] && b_len[k] > 0) begin
                cnt = (b_len[k] > 32) ? 32 : b_len[k];
                exp_q[k].push_back(32'hA000_0000 | (32'(k) << 26) |
                                   ((b_len[k] > 32) ? 32'h0100_0000 : 32'h0) | 32'(cnt));
                for (int i = 0; i < cnt; i++) exp_q[k].push_back(w[k][i]);
                exp_words += 1 + cnt;
            end
            if (b_len[k] > 32) ovf_exp[k] = 1'b1;
            if (b_start[k] + b_len[k] > last_c) last_c = b_start[k] + b_len[k];
        end
        for (int c = 0; c <= last_c; c++) begin
            for (int k = 0; k < 4; k++) begin
                act = c >= b_start[k] && c < b_start[k] + b_len[k];
                cmd[k] = act;
                sdata[32*k +: 32] = act ? w[k][c - b_start[k]] : $urandom;
            end
            lif.m_Log_Ready = toggle ? !lif.m_Log_Ready : ($urandom_range(99) < ready_pct);
            tick();
        end
        cmd = '0;
    endtask

    task automatic score();
        logic [31:0] h, tmpl, d;
        logic        l;
        logic [1:0]  ch;
        int          cnt;
        while (rx_data_q.size() > 0) begin
            h  = rx_data_q.pop_front();
            l  = rx_last_q.pop_front();
            ch = h[27:26];
            check("hdr_last", 32'(l), 32'd0);
            if (exp_q[ch].size() == 0) begin
                check("frame_expected", 32'(exp_q[ch].size()), 32'd1);
                rx_data_q.delete();
                rx_last_q.delete();
                break;
            end
            tmpl = exp_q[ch].pop_front();
            check("header", h, tmpl | (32'(model_seq & 16'hFFFF) << 8));
            model_seq++;
            cnt = int'(tmpl[7:0]);
            for (int i = 0; i < cnt; i++) begin
                if (rx_data_q.size() == 0) begin
                    check("payload_count", 32'(i), 32'(cnt));
                    break;
                end
                d = rx_data_q.pop_front();
                l = rx_last_q.pop_front();
                check("payload", d, exp_q[ch].pop_front());
                check("payload_last", 32'(l), 32'(i == cnt - 1));
            end
        end
        for (int k = 0; k < 4; k++) begin
            check("leftover_frames", 32'(exp_q[k].size()), 32'd0);
            exp_q[k].delete();
        end
        exp_words = 0;
    endtask

    task automatic drain(input int ready_pct, input bit toggle);
        int n = 0;
        while (rx_data_q.size() < exp_words && n < 4000) begin
            lif.m_Log_Ready = toggle ? !lif.m_Log_Ready : ($urandom_range(99) < ready_pct);
            tick();
            n++;
        end
        lif.m_Log_Ready = 1'b1;
        repeat (4) tick();
        check("drain_words", 32'(rx_data_q.size()), 32'(exp_words));
        check("idle_valid", 32'(lif.m_Log_Valid), 32'd0);
    endtask

    task automatic check_at(input string tag, input int idx, input logic [31:0] exp);
        if (rx_data_q.size() > idx) check(tag, rx_data_q[idx], exp);
        else check({tag, "_missing"}, 32'(rx_data_q.size()), 32'(idx + 1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_valid", 32'(lif.m_Log_Valid), 32'd0);
        check("rst_data", lif.m_Log_Data, 32'd0);
        check("rst_last", 32'(lif.m_Log_Last), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);

        // Single burst on ch0, twice: seq 0 then seq 1.
        clear_bursts();
        b_len[0] = 27;
        run_bursts(1'b1, 100, 1'b0);
        drain(100, 1'b0);
        check_at("single_hdr", 0, 32'hA000_001B);
        check_at("single_w1", 1, 32'h0001_0000);
        check_at("single_w27", 27, 32'h001B_0000);
        score();
        run_bursts(1'b1, 100, 1'b0);
        drain(100, 1'b0);
        check_at("single_seq1", 0, 32'hA000_011B);
        score();

        // All four channels end together: strict round-robin order.
        do_reset();
        clear_bursts();
        for (int k = 0; k < 4; k++) b_len[k] = 27;
        run_bursts(1'b1, 100, 1'b0);
        drain(100, 1'b0);
        check_at("rr_ch0", 0,  32'hA000_001B);
        check_at("rr_ch1", 28, 32'hA400_011B);
        check_at("rr_ch2", 56, 32'hA800_021B);
        check_at("rr_ch3", 84, 32'hAC00_031B);
        score();

        // Overflow on ch2.
        do_reset();
        clear_bursts();
        b_len[2] = 40;
        run_bursts(1'b1, 100, 1'b0);
        drain(100, 1'b0);
        check_at("ovf_hdr", 0, 32'hA900_0020);
        score();
        check("ovf_flags", 32'(ovf), 32'h4);
        pulse_clr();
        check("ovf_clr", 32'(ovf), 32'h0);

        // Drop: second ch1 burst arrives while the first is still pending.
        clear_bursts();
        b_len[1] = 27;
        run_bursts(1'b1, 0, 1'b0);
        repeat (3) tick();
        b_len[1] = 10;
        b_keep[1] = 1'b0;
        run_bursts(1'b0, 0, 1'b0);
        tick();
        check("drop_flags", 32'(drop), 32'h2);
        drain(100, 1'b0);
        check_at("drop_hdr", 0, 32'hA400_011B);
        score();
        pulse_clr();
        check("drop_clr", 32'(drop), 32'h0);

        // Backpressure with Ready toggling every cycle.
        clear_bursts();
        b_len[3] = 27;
        run_bursts(1'b0, 0, 1'b1);
        drain(0, 1'b1);
        score();

        // Reset in the middle of a frame.
        clear_bursts();
        b_len[0] = 27;
        run_bursts(1'b1, 100, 1'b0);
        for (int n = 0; n < 200 && rx_data_q.size() < 6; n++) tick();
        check("mid_words_seen", 32'(rx_data_q.size() >= 6), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(lif.m_Log_Valid), 32'd0);
        clear_model();
        clear_bursts();
        b_len[1] = 5;
        run_bursts(1'b1, 100, 1'b0);
        drain(100, 1'b0);
        check_at("mid_rst_hdr", 0, 32'hA400_0005);
        score();

        // Random rounds.
        for (int r = 0; r < 10; r++) begin
            int pct;
            clear_bursts();
            pct = int'($urandom_range(20, 100));
            for (int k = 0; k < 4; k++) begin
                b_len[k]   = int'($urandom_range(0, 40));
                b_start[k] = int'($urandom_range(0, 6));
            end
            run_bursts(1'b0, pct, 1'b0);
            drain(pct, 1'b0);
            score();
            check("rnd_ovf", 32'(ovf), 32'(ovf_exp));
            check("rnd_drop", 32'(drop), 32'h0);
            pulse_clr();
            ovf_exp = '0;
            check("rnd_ovf_clr", 32'(ovf), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
